risc_r_ctrl_fsm: RTL and testbench
==================================

Name: risc_r_ctrl_fsm

Overview:
Multi-cycle control sequencer for the R-type RISC-V datapath. It steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK.
- Owns the instruction-memory request/acknowledge handshake.
- Decodes R-type fields into register-file addresses and an ALU opcode.
- Gates register write-back and PC increment.
- Detects illegal instructions and fetch timeouts, and counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter (saturating)
TIMEOUT, 16, max FETCH cycles waiting for imem_ack before fault (>=2)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin execution from IDLE (level, sampled in IDLE only)
stop  in  1  request return to IDLE after current instruction retires
imem_req  out  1  instruction fetch request, held until ack
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction word
ir_load  out  1  one-cycle pulse: datapath latches instruction
rf_rd_en  out  1  register-file read enable
rs1_addr  out  5  source register 1
rs2_addr  out  5  source register 2
rd_addr  out  5  destination register
alu_op  out  4  ALU operation code
rf_wr_en  out  1  register-file write pulse
pc_inc  out  1  one-cycle PC+4 pulse
busy  out  1  high in any state except IDLE/HALT
illegal  out  1  sticky: undecodable instruction
fetch_fault  out  1  sticky: imem_ack timeout
instr_count  out  CNT_W  retired instructions, saturates at all-ones

Behaviour:
- Clock/reset: single clock; reset is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including the internal IR, wait counter and instr_count.
  - Reset asserted mid-instruction aborts it: no rf_wr_en or pc_inc in the reset cycle or after it.
- All outputs are registered.
- States are IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE:
  - start=1 moves to FETCH next cycle.
  - Outputs idle.
- FETCH:
  - imem_req=1 every cycle in FETCH.
  - Wait counter increments each cycle without ack.
  - imem_ack=1: IR<=imem_rdata, ir_load=1 for the following cycle, go DECODE, counter cleared.
  - Wait counter reaching TIMEOUT with no ack: fetch_fault<=1, go HALT.
  - Ack arriving on the same cycle the counter reaches TIMEOUT is accepted; no fault is raised.
- DECODE:
  - rs1=IR[19:15], rs2=IR[24:20], rd=IR[11:7], rf_rd_en=1.
  - alu_op comes from funct7/funct3.
  - Legal only when opcode IR[6:0]=0110011 and one of:
    - funct7=0000000 with any funct3: 000 ADD=0, 001 SLL=2, 010 SLT=3, 011 SLTU=4, 100 XOR=5, 101 SRL=6, 110 OR=8, 111 AND=9.
    - funct7=0100000 with funct3 000 (SUB=1) or 101 (SRA=7).
  - Otherwise: illegal<=1, go HALT. rf_rd_en, rf_wr_en and pc_inc stay 0.
- EXECUTE:
  - Lasts one cycle.
  - Addresses, alu_op and rf_rd_en are held.
- WRITEBACK:
  - Addresses and alu_op are held.
  - rf_wr_en=1 for one cycle unless rd_addr=0; writes to x0 are suppressed but the instruction still retires.
  - pc_inc=1.
  - instr_count+1, saturating.
  - Next state is IDLE if stop was seen high at any point since the current FETCH began, else FETCH.
- HALT:
  - Terminal until reset; start is ignored.
  - busy=0, illegal/fetch_fault held.
- Latency: with zero-wait ack, one instruction takes 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
  - rf_wr_en asserts 3 cycles after the ack cycle.
- stop and start both high in IDLE: start wins for one instruction, then return to IDLE.

Decomposition:
- Shared package risc_r_pkg holds:
  - OPC_RTYPE=7'b0110011, F7_BASE, F7_ALT.
  - The 4-bit ALU opcode localparams listed above; the ALU uses the same package.
  - The state enumeration.
- One combinational sub-module, risc_r_decode: IR in; rs1/rs2/rd, alu_op, legal out. It is reusable by a later pipelined core.

Test Plan:
1. Reset:
   - Assert reset 2 cycles.
   - All outputs 0, state IDLE, busy=0.
   - With start=0 and reset deasserted, imem_req stays 0.
2. ADD x3,x1,x2 (0x002081B3), start=1, ack on first FETCH cycle:
   - ir_load the next cycle.
   - rs1=1, rs2=2, rd=3, alu_op=0.
   - rf_wr_en and pc_inc exactly 3 cycles after the ack cycle.
   - instr_count=1.
3. SUB x5,x6,x7 (0x407302B3) with 3-cycle ack delay:
   - imem_req high 4 cycles.
   - alu_op=1, rd=5, instr_count=2.
   - Then ADD x0,x1,x2 (0x00208033): rf_wr_en stays 0, pc_inc=1, instr_count=3.
4. ADDI word 0x00500093:
   - illegal=1, state HALT, no rf_wr_en/pc_inc.
   - start=1 ignored.
   - reset clears illegal.
5. TIMEOUT=16, imem_ack held 0:
   - fetch_fault=1 after 16 FETCH cycles, busy=0.
   - A repeat run with ack on cycle 16 gives no fault and normal retire.
6. Reset mid-run and stop:
   - Reset asserted during EXECUTE of an ADD: no rf_wr_en/pc_inc, all outputs 0 next cycle.
   - Separately, stop pulsed during FETCH: instruction retires, state returns to IDLE.

Source files
------------

// File: rtl/risc_r_pkg.sv
// Shared definitions for the R-type RISC-V control path and ALU:
// opcode/funct7 encodings, ALU operation codes and the sequencer states.
package risc_r_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

endpackage

// File: rtl/risc_r_ctrl_fsm_if.sv
// Instruction-memory fetch handshake: request held until acknowledged,
// data valid in the acknowledge cycle.
interface risc_r_ctrl_fsm_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, output imem_ack, output imem_rdata);
endinterface

// File: rtl/risc_r_decode.sv
// Combinational R-type field decoder: register addresses, ALU opcode and
// a legality flag. Kept stateless so a pipelined core can reuse it.
module risc_r_decode
  import risc_r_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [3:0]  alu_op,
  output logic        legal
);

  logic [6:0] funct7;
  logic [2:0] funct3;

  assign funct7 = ir[31:25];
  assign funct3 = ir[14:12];

  // Field extraction plus funct7/funct3 to ALU opcode mapping.
  always_comb begin
    rs1    = ir[19:15];
    rs2    = ir[24:20];
    rd     = ir[11:7];
    alu_op = ALU_ADD;
    legal  = 1'b0;
    if (ir[6:0] == OPC_RTYPE) begin
      if (funct7 == F7_BASE) begin
        legal = 1'b1;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = ALU_SRL;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
        endcase
      end else if (funct7 == F7_ALT) begin
        case (funct3)
          3'b000: begin legal = 1'b1; alu_op = ALU_SUB; end
          3'b101: begin legal = 1'b1; alu_op = ALU_SRA; end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/risc_r_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for R-type
// instructions. Every output is a register loaded from next-state logic.
module risc_r_ctrl_fsm
  import risc_r_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  risc_r_ctrl_fsm_if.master  imem,
  output logic               ir_load,
  output logic               rf_rd_en,
  output logic [4:0]         rs1_addr,
  output logic [4:0]         rs2_addr,
  output logic [4:0]         rd_addr,
  output logic [3:0]         alu_op,
  output logic               rf_wr_en,
  output logic               pc_inc,
  output logic               busy,
  output logic               illegal,
  output logic               fetch_fault,
  output logic [CNT_W-1:0]   instr_count
);

  localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t             state_reg, state_next;
  logic [31:0]        ir_reg, ir_next;
  logic [WAIT_W-1:0]  wait_reg, wait_next;
  logic               stop_seen_reg, stop_seen_next;
  logic               imem_req_reg, imem_req_next;
  logic               ir_load_reg, ir_load_next;
  logic               rf_rd_en_reg, rf_rd_en_next;
  logic [4:0]         rs1_reg, rs1_next, rs2_reg, rs2_next, rd_reg, rd_next;
  logic [3:0]         alu_op_reg, alu_op_next;
  logic               rf_wr_en_reg, rf_wr_en_next;
  logic               pc_inc_reg, pc_inc_next;
  logic               busy_reg, busy_next;
  logic               illegal_reg, illegal_next;
  logic               fault_reg, fault_next;
  logic [CNT_W-1:0]   count_reg, count_next;

  // During FETCH the decoder looks at the incoming word so the register
  // addresses are already registered when DECODE begins; afterwards it
  // looks at the latched IR for the legality decision.
  logic [31:0] dec_ir;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [3:0]  dec_alu_op;
  logic        dec_legal;

  assign dec_ir = (state_reg == ST_FETCH) ? imem.imem_rdata : ir_reg;

  risc_r_decode u_decode (
    .ir     (dec_ir),
    .rs1    (dec_rs1),
    .rs2    (dec_rs2),
    .rd     (dec_rd),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  // State and output registers; reset aborts any instruction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      ir_reg        <= '0;
      wait_reg      <= '0;
      stop_seen_reg <= 1'b0;
      imem_req_reg  <= 1'b0;
      ir_load_reg   <= 1'b0;
      rf_rd_en_reg  <= 1'b0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      rd_reg        <= '0;
      alu_op_reg    <= '0;
      rf_wr_en_reg  <= 1'b0;
      pc_inc_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      illegal_reg   <= 1'b0;
      fault_reg     <= 1'b0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      ir_reg        <= ir_next;
      wait_reg      <= wait_next;
      stop_seen_reg <= stop_seen_next;
      imem_req_reg  <= imem_req_next;
      ir_load_reg   <= ir_load_next;
      rf_rd_en_reg  <= rf_rd_en_next;
      rs1_reg       <= rs1_next;
      rs2_reg       <= rs2_next;
      rd_reg        <= rd_next;
      alu_op_reg    <= alu_op_next;
      rf_wr_en_reg  <= rf_wr_en_next;
      pc_inc_reg    <= pc_inc_next;
      busy_reg      <= busy_next;
      illegal_reg   <= illegal_next;
      fault_reg     <= fault_next;
      count_reg     <= count_next;
    end
  end

  // Next-state and next-output logic; pulses default low, fields hold.
  always_comb begin
    state_next     = state_reg;
    ir_next        = ir_reg;
    wait_next      = wait_reg;
    stop_seen_next = stop_seen_reg;
    imem_req_next  = 1'b0;
    ir_load_next   = 1'b0;
    rf_rd_en_next  = 1'b0;
    rs1_next       = rs1_reg;
    rs2_next       = rs2_reg;
    rd_next        = rd_reg;
    alu_op_next    = alu_op_reg;
    rf_wr_en_next  = 1'b0;
    pc_inc_next    = 1'b0;
    illegal_next   = illegal_reg;
    fault_next     = fault_reg;
    count_next     = count_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next     = ST_FETCH;
          imem_req_next  = 1'b1;
          wait_next      = '0;
          // stop alongside start still lets one instruction run first
          stop_seen_next = stop;
        end
      end
      ST_FETCH: begin
        stop_seen_next = stop_seen_reg | stop;
        if (imem.imem_ack) begin
          state_next    = ST_DECODE;
          ir_next       = imem.imem_rdata;
          ir_load_next  = 1'b1;
          rs1_next      = dec_rs1;
          rs2_next      = dec_rs2;
          rd_next       = dec_rd;
          alu_op_next   = dec_alu_op;
          rf_rd_en_next = dec_legal;
          wait_next     = '0;
        end else if (wait_reg == WAIT_LAST) begin
          state_next = ST_HALT;
          fault_next = 1'b1;
          wait_next  = '0;
        end else begin
          wait_next     = wait_reg + 1'b1;
          imem_req_next = 1'b1;
        end
      end
      ST_DECODE: begin
        stop_seen_next = stop_seen_reg | stop;
        if (dec_legal) begin
          state_next    = ST_EXECUTE;
          rf_rd_en_next = 1'b1;
        end else begin
          state_next   = ST_HALT;
          illegal_next = 1'b1;
        end
      end
      ST_EXECUTE: begin
        stop_seen_next = stop_seen_reg | stop;
        state_next     = ST_WRITEBACK;
        rf_wr_en_next  = (rd_reg != 5'd0);
        pc_inc_next    = 1'b1;
        if (count_reg != '1) count_next = count_reg + 1'b1;
      end
      ST_WRITEBACK: begin
        stop_seen_next = 1'b0;
        if (stop_seen_reg || stop) begin
          state_next = ST_IDLE;
        end else begin
          state_next    = ST_FETCH;
          imem_req_next = 1'b1;
          wait_next     = '0;
        end
      end
      ST_HALT: ;
      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next != ST_IDLE) && (state_next != ST_HALT);
  end

  assign imem.imem_req = imem_req_reg;
  assign ir_load       = ir_load_reg;
  assign rf_rd_en      = rf_rd_en_reg;
  assign rs1_addr      = rs1_reg;
  assign rs2_addr      = rs2_reg;
  assign rd_addr       = rd_reg;
  assign alu_op        = alu_op_reg;
  assign rf_wr_en      = rf_wr_en_reg;
  assign pc_inc        = pc_inc_reg;
  assign busy          = busy_reg;
  assign illegal       = illegal_reg;
  assign fetch_fault   = fault_reg;
  assign instr_count   = count_reg;

endmodule

// File: tb/tb_risc_r_ctrl_fsm.sv
// Directed bench for the R-type control sequencer: reset, ADD/SUB/x0
// retire, illegal word, fetch timeout boundary, mid-run reset and stop.
module tb_risc_r_ctrl_fsm;
  import risc_r_pkg::*;

  logic        clock = 1'b0;
  logic        reset, start, stop;
  logic        ir_load, rf_rd_en, rf_wr_en, pc_inc, busy, illegal, fetch_fault;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [3:0]  alu_op;
  logic [15:0] instr_count;
  int          checks = 0;
  int          errors = 0;
  int          req_n;

  risc_r_ctrl_fsm_if bus ();

  risc_r_ctrl_fsm #(.CNT_W(16), .TIMEOUT(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .imem        (bus),
    .ir_load     (ir_load),
    .rf_rd_en    (rf_rd_en),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .alu_op      (alu_op),
    .rf_wr_en    (rf_wr_en),
    .pc_inc      (pc_inc),
    .busy        (busy),
    .illegal     (illegal),
    .fetch_fault (fetch_fault),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  // Advance one clock; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0;

    // 1. reset
    tick(); tick();
    chk("rst_state", dut.state_reg, ST_IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_outs", {ir_load, rf_rd_en, rf_wr_en, pc_inc, illegal, fetch_fault}, 0);
    chk("rst_fields", {rs1_addr, rs2_addr, rd_addr, alu_op}, 0);
    chk("rst_count", instr_count, 0);
    reset = 1'b0;
    tick(); tick();
    chk("idle_req", bus.imem_req, 0);
    chk("idle_busy", busy, 0);

    // 2. ADD x3,x1,x2 with zero-wait ack
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("add_fetch_req", bus.imem_req, 1);
    chk("add_fetch_busy", busy, 1);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h002081B3;
    tick();
    bus.imem_ack = 1'b0;
    chk("add_ir_load", ir_load, 1);
    chk("add_req_drop", bus.imem_req, 0);
    chk("add_fields", {rs1_addr, rs2_addr, rd_addr, alu_op}, {5'd1, 5'd2, 5'd3, 4'd0});
    chk("add_rd_en", rf_rd_en, 1);
    chk("add_dec_wr", {rf_wr_en, pc_inc}, 0);
    tick();
    chk("add_exec_ld", ir_load, 0);
    chk("add_exec_wr", {rf_wr_en, pc_inc}, 0);
    chk("add_exec_rd_en", rf_rd_en, 1);
    tick();
    chk("add_wb_wr", {rf_wr_en, pc_inc}, 2'b11);
    chk("add_count", instr_count, 1);
    chk("add_wb_fields", {rs1_addr, rs2_addr, rd_addr, alu_op}, {5'd1, 5'd2, 5'd3, 4'd0});
    tick();
    chk("add_next_fetch", dut.state_reg, ST_FETCH);
    chk("add_pulse_end", {rf_wr_en, pc_inc}, 0);

    // 3. SUB x5,x6,x7 with three wait cycles, then ADD x0
    req_n = 0;
    repeat (3) begin
      if (bus.imem_req) req_n++;
      tick();
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h407302B3;
    if (bus.imem_req) req_n++;
    tick();
    bus.imem_ack = 1'b0;
    chk("sub_req_cycles", req_n, 4);
    chk("sub_req_drop", bus.imem_req, 0);
    chk("sub_fields", {rs1_addr, rs2_addr, rd_addr, alu_op}, {5'd6, 5'd7, 5'd5, 4'd1});
    tick(); tick();
    chk("sub_wb_wr", {rf_wr_en, pc_inc}, 2'b11);
    chk("sub_count", instr_count, 2);
    tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00208033;
    tick();
    bus.imem_ack = 1'b0;
    chk("x0_rd", rd_addr, 0);
    tick(); tick();
    chk("x0_wb_wr", {rf_wr_en, pc_inc}, 2'b01);
    chk("x0_count", instr_count, 3);

    // 4. ADDI word is illegal
    tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h00500093;
    tick();
    bus.imem_ack = 1'b0;
    chk("ill_dec_rd_en", rf_rd_en, 0);
    tick();
    chk("ill_flag", illegal, 1);
    chk("ill_state", dut.state_reg, ST_HALT);
    chk("ill_busy", busy, 0);
    chk("ill_wr", {rf_wr_en, pc_inc, rf_rd_en}, 0);
    chk("ill_count", instr_count, 3);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("halt_ignores_start", dut.state_reg, ST_HALT);
    chk("halt_ill_held", illegal, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ill_cleared", illegal, 0);
    chk("ill_rst_count", instr_count, 0);

    // 5. fetch timeout: 16 FETCH cycles without ack
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    chk("to_c16_req", bus.imem_req, 1);
    chk("to_c16_fault", fetch_fault, 0);
    tick();
    chk("to_fault", fetch_fault, 1);
    chk("to_busy", busy, 0);
    chk("to_state", dut.state_reg, ST_HALT);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("to_fault_clr", fetch_fault, 0);
    // ack on the 16th FETCH cycle is accepted
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h002081B3;
    tick();
    bus.imem_ack = 1'b0;
    chk("to16_no_fault", fetch_fault, 0);
    chk("to16_ir_load", ir_load, 1);
    tick(); tick();
    chk("to16_wb_wr", {rf_wr_en, pc_inc}, 2'b11);
    chk("to16_count", instr_count, 1);

    // 6a. reset during EXECUTE aborts the instruction
    tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h002081B3;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    chk("abort_in_exec", dut.state_reg, ST_EXECUTE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_wr", {rf_wr_en, pc_inc}, 0);
    chk("abort_outs", {ir_load, rf_rd_en, busy, bus.imem_req, illegal, fetch_fault}, 0);
    chk("abort_fields", {rs1_addr, rs2_addr, rd_addr, alu_op}, 0);
    chk("abort_count", instr_count, 0);
    chk("abort_state", dut.state_reg, ST_IDLE);
    tick();
    chk("abort_after", {rf_wr_en, pc_inc}, 0);

    // 6b. stop pulsed during FETCH: retire, then IDLE
    start = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h0020C1B3;
    tick();
    bus.imem_ack = 1'b0;
    chk("stop_xor_op", alu_op, 5);
    tick(); tick();
    chk("stop_wb_wr", {rf_wr_en, pc_inc}, 2'b11);
    chk("stop_count", instr_count, 1);
    tick();
    chk("stop_idle", dut.state_reg, ST_IDLE);
    chk("stop_busy", {busy, bus.imem_req}, 0);
    tick();
    chk("stop_stays_idle", dut.state_reg, ST_IDLE);

    // start and stop together: one instruction, then IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h4020D1B3;
    tick();
    bus.imem_ack = 1'b0;
    chk("both_sra_op", alu_op, 7);
    tick(); tick();
    chk("both_count", instr_count, 2);
    tick();
    chk("both_idle", dut.state_reg, ST_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
